// File: rtl/wb_burst_master_pkg.sv
// Shared constants and state type for the Wishbone B4 burst master.
package wb_burst_master_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_burst_master_buf.sv
// DEPTH x WIDTH register buffer: one synchronous write port and one
// combinational read port. Contents are intentionally not reset.
module wb_burst_master_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; no reset so data survives across commands and resets.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B4 master engine: single access or incrementing burst of up to
// MAX_BURST beats, with write staging and read capture buffers.
// Optional macro WB_BURST_MASTER_TIMEOUT_EN adds a per-beat ACK timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | cmd_ready high, waiting for a command
// ST_BUS  | CYC/STB asserted, one beat per ACK
// ST_RESP | rsp_valid high, holding the result until rsp_ready
module wb_burst_master
  import wb_burst_master_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [WB_ADDR_WIDTH-1:0]      cmd_adr,
  input  logic                          cmd_we,
  input  logic [$clog2(MAX_BURST)-1:0]  cmd_len,
  input  logic [WB_DATA_WIDTH/8-1:0]    cmd_sel,
  input  logic                          wbuf_we,
  input  logic [$clog2(MAX_BURST)-1:0]  wbuf_idx,
  input  logic [WB_DATA_WIDTH-1:0]      wbuf_dat,
  input  logic [$clog2(MAX_BURST)-1:0]  rbuf_idx,
  output logic [WB_DATA_WIDTH-1:0]      rbuf_dat,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_err,
  output logic [$clog2(MAX_BURST):0]    rsp_beats,
  output logic [WB_ADDR_WIDTH-1:0]      adr,
  output logic [WB_DATA_WIDTH-1:0]      dat_w,
  output logic [WB_DATA_WIDTH/8-1:0]    sel,
  output logic [2:0]                    cti,
  output logic [1:0]                    bte,
  output logic                          we,
  output logic                          cyc,
  output logic                          stb,
  input  logic [WB_DATA_WIDTH-1:0]      dat_r,
  input  logic                          ack,
  input  logic                          err
);

  localparam int LW    = $clog2(MAX_BURST);
  localparam int BYTES = WB_DATA_WIDTH / 8;

  if (MAX_BURST < 2 || (MAX_BURST & (MAX_BURST - 1)) != 0 || TIMEOUT_CYCLES < 1 ||
      (WB_DATA_WIDTH % 8) != 0) begin : g_bad_param
    $error("wb_burst_master: illegal parameter combination");
  end

  state_t                     state, state_nxt;
  logic [WB_ADDR_WIDTH-1:0]   adr_q;
  logic                       we_q;
  logic [LW-1:0]              len_q;
  logic [BYTES-1:0]           sel_q;
  logic [LW:0]                beat;
  logic                       err_q;
  logic                       last_beat;
  logic                       in_bus;
  logic                       accept;
  logic                       tmo_hit;
  logic [WB_DATA_WIDTH-1:0]   wbuf_rd;
  logic [WB_DATA_WIDTH-1:0]   rbuf_rd;

  assign in_bus    = (state == ST_BUS);
  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign last_beat = (beat[LW-1:0] == len_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and bus/handshake outputs; everything is zero outside ST_BUS.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    cyc       = 1'b0;
    stb       = 1'b0;
    we        = 1'b0;
    adr       = '0;
    dat_w     = '0;
    sel       = '0;
    cti       = CTI_CLASSIC;
    bte       = BTE_LINEAR;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ST_BUS;
      end
      ST_BUS: begin
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = we_q;
        adr   = adr_q + WB_ADDR_WIDTH'(beat) * WB_ADDR_WIDTH'(BYTES);
        dat_w = we_q ? wbuf_rd : '0;
        sel   = sel_q;
        if (len_q == '0)    cti = CTI_CLASSIC;
        else if (last_beat) cti = CTI_EOB;
        else                cti = CTI_INCR;
        // ERR and timeout end the burst regardless of ACK.
        if (err || tmo_hit || (ack && last_beat)) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, beat counter and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q <= '0;
      we_q  <= 1'b0;
      len_q <= '0;
      sel_q <= '0;
      beat  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      adr_q <= cmd_adr;
      we_q  <= cmd_we;
      len_q <= cmd_len;
      sel_q <= cmd_sel;
      beat  <= '0;
      err_q <= 1'b0;
    end else if (in_bus) begin
      if (err || tmo_hit) err_q <= 1'b1;
      else if (ack)       beat  <= beat + (LW+1)'(1);
    end
  end

  assign rsp_err   = err_q;
  assign rsp_beats = beat;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Per-beat down-counter, reloaded whenever the bus is not stalled.
  always_ff @(posedge clk) begin
    if (rst || !in_bus || ack || err) tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if (tmo_cnt != '0)           tmo_cnt <= tmo_cnt - TW'(1);
  end

  assign tmo_hit = in_bus && !ack && !err && (tmo_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  wb_burst_master_buf #(.DEPTH(MAX_BURST), .WIDTH(WB_DATA_WIDTH)) u_wbuf (
    .clk   (clk),
    .we    (wbuf_we && !in_bus),
    .waddr (wbuf_idx),
    .wdata (wbuf_dat),
    .raddr (beat[LW-1:0]),
    .rdata (wbuf_rd)
  );

  wb_burst_master_buf #(.DEPTH(MAX_BURST), .WIDTH(WB_DATA_WIDTH)) u_rbuf (
    .clk   (clk),
    .we    (in_bus && ack && !err && !we_q),
    .waddr (beat[LW-1:0]),
    .wdata (dat_r),
    .raddr (rbuf_idx),
    .rdata (rbuf_rd)
  );

  // Registered read-buffer port.
  always_ff @(posedge clk) begin
    if (rst) rbuf_dat <= '0;
    else     rbuf_dat <= rbuf_rd;
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed self-checking bench for wb_burst_master (32-bit instance plus an
// 8-bit-address instance for the wrap case).
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [3:0]  cmd_len = '0, cmd_sel = '0;
  logic        wbuf_we = 1'b0;
  logic [3:0]  wbuf_idx = '0, rbuf_idx = '0;
  logic [31:0] wbuf_dat = '0, dat_r = '0;
  logic        ack = 1'b0, err = 1'b0;

  logic        cmd_ready, rsp_valid, rsp_err, we, cyc, stb;
  logic [31:0] rbuf_dat, adr, dat_w;
  logic [4:0]  rsp_beats;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic        cmd_valid8 = 1'b0, rsp_ready8 = 1'b0, ack8 = 1'b0, err8 = 1'b0;
  logic [31:0] dat_r8 = '0;
  logic        cmd_ready8, rsp_valid8, rsp_err8, we8, cyc8, stb8;
  logic [31:0] rbuf_dat8, dat_w8;
  logic [7:0]  adr8;
  logic [4:0]  rsp_beats8;
  logic [3:0]  sel8;
  logic [2:0]  cti8;
  logic [1:0]  bte8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_burst_master #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MAX_BURST(16),
                    .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_adr(cmd_adr), .cmd_we(cmd_we), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wbuf_we(wbuf_we), .wbuf_idx(wbuf_idx), .wbuf_dat(wbuf_dat),
    .rbuf_idx(rbuf_idx), .rbuf_dat(rbuf_dat), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_beats(rsp_beats),
    .adr(adr), .dat_w(dat_w), .sel(sel), .cti(cti), .bte(bte), .we(we),
    .cyc(cyc), .stb(stb), .dat_r(dat_r), .ack(ack), .err(err)
  );

  wb_burst_master #(.WB_ADDR_WIDTH(8), .WB_DATA_WIDTH(32), .MAX_BURST(16),
                    .TIMEOUT_CYCLES(8)) u_dut8 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
    .cmd_adr(cmd_adr[7:0]), .cmd_we(cmd_we), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wbuf_we(wbuf_we), .wbuf_idx(wbuf_idx), .wbuf_dat(wbuf_dat),
    .rbuf_idx(rbuf_idx), .rbuf_dat(rbuf_dat8), .rsp_valid(rsp_valid8),
    .rsp_ready(rsp_ready8), .rsp_err(rsp_err8), .rsp_beats(rsp_beats8),
    .adr(adr8), .dat_w(dat_w8), .sel(sel8), .cti(cti8), .bte(bte8), .we(we8),
    .cyc(cyc8), .stb(stb8), .dat_r(dat_r8), .ack(ack8), .err(err8)
  );

  // Inputs change and outputs are sampled at the falling edge.
  task automatic issue_cmd(input logic [31:0] a, input logic w, input logic [3:0] l,
                           input logic [3:0] s);
    cmd_adr = a; cmd_we = w; cmd_len = l; cmd_sel = s; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic stage_write(input logic [3:0] i, input logic [31:0] d);
    wbuf_we = 1'b1; wbuf_idx = i; wbuf_dat = d;
    @(negedge clk);
    wbuf_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cyc, stb, we, cti, bte, sel} !== 13'h0) begin
      n_bad++; $display("FAIL reset_bus: got %h want 0", {cyc, stb, we, cti, bte, sel});
    end
    n_cmp++;
    if (adr !== 32'h0 || dat_w !== 32'h0) begin
      n_bad++; $display("FAIL reset_adr_dat: got adr=%h dat_w=%h want 0/0", adr, dat_w);
    end
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_beats} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      n_bad++; $display("FAIL reset_hs: got %b want 1_0_0_00000",
                        {cmd_ready, rsp_valid, rsp_err, rsp_beats});
    end
    n_cmp++;
    if (rbuf_dat !== 32'h0) begin
      n_bad++; $display("FAIL reset_rbuf_dat: got %h want 0", rbuf_dat);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    stage_write(4'd0, 32'hDEADBEEF);
    issue_cmd(32'h100, 1'b1, 4'd0, 4'hF);
    n_cmp++;
    if ({cyc, stb, we, cmd_ready, cti, bte, sel} !== {4'b1110, 3'b000, 2'b00, 4'hF}) begin
      n_bad++; $display("FAIL sw_ctrl: got %b want 1110_000_00_1111",
                        {cyc, stb, we, cmd_ready, cti, bte, sel});
    end
    n_cmp++;
    if (adr !== 32'h100 || dat_w !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL sw_adr_dat: got %h/%h want 00000100/deadbeef", adr, dat_w);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_cmp++;
    if ({cyc, stb, rsp_valid, rsp_err, rsp_beats} !== {4'b0010, 5'd1}) begin
      n_bad++; $display("FAIL sw_rsp: got %b want 0010_00001",
                        {cyc, stb, rsp_valid, rsp_err, rsp_beats});
    end
    finish_rsp();
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL sw_idle: got %b want 10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_read_burst();
    logic [2:0] exp_cti;
    int stb_cnt = 0;
    issue_cmd(32'h200, 1'b0, 4'd3, 4'hF);
    for (int i = 0; i < 4; i++) begin
      exp_cti = (i == 3) ? 3'b111 : 3'b010;
      if (stb === 1'b1) stb_cnt++;
      n_cmp++;
      if (adr !== 32'h200 + 32'(4 * i) || cti !== exp_cti || we !== 1'b0 || dat_w !== 32'h0) begin
        n_bad++; $display("FAIL rd_beat%0d: got adr=%h cti=%b we=%b dat_w=%h want adr=%h cti=%b we=0 dat_w=0",
                          i, adr, cti, we, dat_w, 32'h200 + 32'(4 * i), exp_cti);
      end
      dat_r = 32'h11 * 32'(i + 1);
      ack = 1'b1;
      @(negedge clk);
    end
    ack = 1'b0; dat_r = '0;
    if (stb === 1'b1) stb_cnt++;
    n_cmp++;
    if (stb_cnt !== 4) begin
      n_bad++; $display("FAIL rd_stb_cycles: got %0d want 4", stb_cnt);
    end
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_beats} !== {2'b10, 5'd4}) begin
      n_bad++; $display("FAIL rd_rsp: got %b want 10_00100", {rsp_valid, rsp_err, rsp_beats});
    end
    finish_rsp();
    for (int i = 0; i < 4; i++) begin
      rbuf_idx = 4'(i);
      @(negedge clk);
      n_cmp++;
      if (rbuf_dat !== 32'h11 * 32'(i + 1)) begin
        n_bad++; $display("FAIL rd_rbuf%0d: got %h want %h", i, rbuf_dat, 32'h11 * 32'(i + 1));
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_d;
    int stb_cnt = 0;
    stage_write(4'd0, 32'hA5A50001);
    stage_write(4'd1, 32'h5A5A0002);
    issue_cmd(32'h300, 1'b1, 4'd1, 4'h3);
    for (int b = 0; b < 2; b++) begin
      exp_d = (b == 0) ? 32'hA5A50001 : 32'h5A5A0002;
      for (int w = 0; w < 4; w++) begin
        if (stb === 1'b1) stb_cnt++;
        n_cmp++;
        if (adr !== 32'h300 + 32'(4 * b) || dat_w !== exp_d || sel !== 4'h3) begin
          n_bad++; $display("FAIL ws_b%0d_w%0d: got adr=%h dat_w=%h sel=%h want adr=%h dat_w=%h sel=3",
                            b, w, adr, dat_w, sel, 32'h300 + 32'(4 * b), exp_d);
        end
        // A staging write during the bus phase must not reach the buffer.
        wbuf_we  = (b == 1 && w == 0);
        wbuf_idx = 4'd1;
        wbuf_dat = 32'hFFFFFFFF;
        ack = (w == 3);
        @(negedge clk);
        wbuf_we = 1'b0;
      end
    end
    ack = 1'b0;
    if (stb === 1'b1) stb_cnt++;
    n_cmp++;
    if (stb_cnt !== 8 || {rsp_valid, rsp_err, rsp_beats} !== {2'b10, 5'd2}) begin
      n_bad++; $display("FAIL ws_rsp: got stb_cycles=%0d rsp=%b want 8 10_00010",
                        stb_cnt, {rsp_valid, rsp_err, rsp_beats});
    end
    finish_rsp();
  endtask

  task automatic test_err();
    logic [31:0] exp_rb [4];
    exp_rb[0] = 32'hA0; exp_rb[1] = 32'hA1; exp_rb[2] = 32'h33; exp_rb[3] = 32'h44;
    issue_cmd(32'h400, 1'b0, 4'd3, 4'hF);
    for (int i = 0; i < 3; i++) begin
      dat_r = (i == 2) ? 32'hEE : 32'hA0 + 32'(i);
      ack = 1'b1;
      err = (i == 2);
      @(negedge clk);
    end
    ack = 1'b0; err = 1'b0; dat_r = '0;
    n_cmp++;
    if ({cyc, stb, rsp_valid, rsp_err, rsp_beats} !== {4'b0011, 5'd2}) begin
      n_bad++; $display("FAIL err_rsp: got %b want 0011_00010",
                        {cyc, stb, rsp_valid, rsp_err, rsp_beats});
    end
    finish_rsp();
    for (int i = 0; i < 4; i++) begin
      rbuf_idx = 4'(i);
      @(negedge clk);
      n_cmp++;
      if (rbuf_dat !== exp_rb[i]) begin
        n_bad++; $display("FAIL err_rbuf%0d: got %h want %h", i, rbuf_dat, exp_rb[i]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    cmd_adr = 32'hFC; cmd_we = 1'b0; cmd_len = 4'd1; cmd_sel = 4'hF; cmd_valid8 = 1'b1;
    @(negedge clk);
    cmd_valid8 = 1'b0;
    n_cmp++;
    if (adr8 !== 8'hFC || cti8 !== 3'b010 || stb8 !== 1'b1) begin
      n_bad++; $display("FAIL wrap_b0: got adr=%h cti=%b stb=%b want fc 010 1", adr8, cti8, stb8);
    end
    ack8 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (adr8 !== 8'h00 || cti8 !== 3'b111 || stb8 !== 1'b1) begin
      n_bad++; $display("FAIL wrap_b1: got adr=%h cti=%b stb=%b want 00 111 1", adr8, cti8, stb8);
    end
    @(negedge clk);
    ack8 = 1'b0;
    n_cmp++;
    if ({rsp_valid8, rsp_err8, rsp_beats8} !== {2'b10, 5'd2}) begin
      n_bad++; $display("FAIL wrap_rsp: got %b want 10_00010", {rsp_valid8, rsp_err8, rsp_beats8});
    end
    rsp_ready8 = 1'b1;
    @(negedge clk);
    rsp_ready8 = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    issue_cmd(32'h500, 1'b0, 4'd3, 4'hF);
    dat_r = 32'h55; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; dat_r = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({cyc, stb, rsp_valid, cmd_ready, rsp_beats} !== {4'b0001, 5'd0}) begin
      n_bad++; $display("FAIL rstmid: got %b want 0001_00000",
                        {cyc, stb, rsp_valid, cmd_ready, rsp_beats});
    end
    @(negedge clk);
    n_cmp++;
    if ({cyc, rsp_valid} !== 2'b00) begin
      n_bad++; $display("FAIL rstmid_after: got %b want 00", {cyc, rsp_valid});
    end
  endtask

  task automatic test_stall();
    int stb_cnt = 0;
    issue_cmd(32'h600, 1'b0, 4'd0, 4'hF);
    for (int c = 0; c < 20 && stb === 1'b1; c++) begin
      stb_cnt++;
      @(negedge clk);
    end
`ifdef WB_BURST_MASTER_TIMEOUT_EN
    n_cmp++;
    if (stb_cnt !== 8 || {rsp_valid, rsp_err, rsp_beats} !== {2'b11, 5'd0}) begin
      n_bad++; $display("FAIL timeout: got stb_cycles=%0d rsp=%b want 8 11_00000",
                        stb_cnt, {rsp_valid, rsp_err, rsp_beats});
    end
`else
    n_cmp++;
    if (stb_cnt !== 20 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL no_timeout: got stb_cycles=%0d rsp_valid=%b want 20 0",
                        stb_cnt, rsp_valid);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_beats} !== {2'b10, 5'd1}) begin
      n_bad++; $display("FAIL stall_rsp: got %b want 10_00001", {rsp_valid, rsp_err, rsp_beats});
    end
`endif
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_wait_states();
    test_err();
    test_addr_wrap();
    test_reset_mid_burst();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Parametrised Wishbone B4 master engine: the synthesisable successor to the single-beat Wishbone master BFM. It accepts a command over a valid/ready handshake and drives a single access or an incrementing burst of up to MAX_BURST beats. Write data comes from an internal staging buffer and read data lands in one. Per-beat ERR termination is supported. It sits between a DPI/transactor front end or an on-chip test sequencer and any wb_if slave.

## Interface
- WB_ADDR_WIDTH, 32, byte address width.
- WB_DATA_WIDTH, 32, data width; multiple of 8.
- MAX_BURST, 16, staging-buffer depth and maximum beats per command; power of two, ≥2.
- TIMEOUT_CYCLES, 1024, per-beat ACK timeout; used only when the timeout feature is compiled in.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_adr  in  WB_ADDR_WIDTH  start byte address.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_len  in  $clog2(MAX_BURST)  beats minus one.
- cmd_sel  in  WB_DATA_WIDTH/8  byte select applied to every beat.
- wbuf_we  in  1  write-staging-buffer write strobe.
- wbuf_idx  in  $clog2(MAX_BURST)  write-staging index.
- wbuf_dat  in  WB_DATA_WIDTH  write-staging data.
- rbuf_idx  in  $clog2(MAX_BURST)  read-buffer index.
- rbuf_dat  out  WB_DATA_WIDTH  read-buffer data, registered.
- rsp_valid  out  1  command complete.
- rsp_ready  in  1  response consumed.
- rsp_err  out  1  burst terminated by ERR or timeout.
- rsp_beats  out  $clog2(MAX_BURST)+1  beats ACKed.
- master  wb_if.master  —  ADR, DAT_W, SEL, CTI, BTE, WE, CYC, STB outputs; DAT_R, ACK, ERR inputs.

## Operation
- States are IDLE, BUS and RESP. cmd_ready = (state==IDLE).
- IDLE → BUS on cmd_valid&&cmd_ready. All cmd_* fields are latched and the beat counter is cleared.
- BUS drives CYC=STB=1, WE=latched cmd_we, SEL=cmd_sel and BTE=2'b00 (linear).
  - Address: ADR = start + beat*(WB_DATA_WIDTH/8), modulo 2^WB_ADDR_WIDTH.
  - CTI: a single-beat command (cmd_len=0) drives 3'b000. Otherwise CTI is 3'b010 on every beat except the last, which drives 3'b111.
  - Write data: DAT_W = wbuf[beat] when writing, 0 when reading.
- On ACK in BUS:
  - For a read, DAT_R is stored to rbuf[beat].
  - The beat counter increments.
  - After the last beat, go to RESP with rsp_err=0.
- ERR in BUS (priority over ACK if both are high) goes to RESP with rsp_err=1. rsp_beats = beats ACKed before the ERR beat, and the ERR beat's data is not stored.
- RESP holds rsp_valid=1 and CYC=STB=0 until rsp_ready, then returns to IDLE.
- wbuf_we is honoured only in IDLE and RESP; writes in BUS are ignored.
- Contents of rbuf entries not written by the current command are retained from earlier commands.

## Timing
- Reset values: CYC, STB, WE, ADR, DAT_W, SEL, CTI, BTE all 0; cmd_ready=1; rsp_valid=0; rsp_err=0; rsp_beats=0; rbuf_dat=0.
- Buffer contents are not cleared by reset.
- Command accepted at edge N gives CYC/STB=1 from cycle N+1.
- Beat advances at the edge sampling ACK. With zero-wait-state ACK, an L-beat burst occupies exactly L cycles of STB.
- ACK or ERR at edge M sets CYC/STB=0 and rsp_valid=1 from cycle M+1.
- rsp_valid&&rsp_ready at edge R gives cmd_ready=1 from R+1. Command-to-command minimum spacing is L+2 cycles.
- rbuf_dat = rbuf[rbuf_idx] sampled at the previous edge; the latency is 1.
- rst asserted in BUS drops CYC/STB at that edge. The in-flight response is discarded and the state goes to IDLE.

## Configuration
- WB_BURST_MASTER_TIMEOUT_EN defined:
  - Adds a per-beat counter that clears on every beat advance.
  - If TIMEOUT_CYCLES consecutive BUS cycles pass without ACK or ERR, the block goes to RESP with rsp_err=1 and rsp_beats = beats completed.
- Undefined: no counter, and BUS waits indefinitely for ACK/ERR.

## Structure
- Package wb_burst_master_pkg holds:
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111;
  - BTE_LINEAR=2'b00;
  - the state enum.
- Sub-module wb_burst_master_buf: a MAX_BURST×WB_DATA_WIDTH two-port register buffer, instantiated twice (write staging, read capture).

## Test plan
- Single write: wbuf[0]=0xDEADBEEF, cmd adr=0x100, len=0, sel=4'hF → one beat; ADR=0x100, CTI=000, DAT_W=0xDEADBEEF; rsp_err=0, rsp_beats=1.
- 4-beat read burst at 0x200 with zero-wait ACK, slave data 0x11,0x22,0x33,0x44:
  - bus: ADR 0x200,0x204,0x208,0x20C; CTI 010,010,010,111; STB high exactly 4 cycles.
  - buffer: rbuf[0..3] read back with 1-cycle latency.
- Wait states: slave stalls ACK 3 cycles per beat on a 2-beat write → ADR/DAT_W stable during the stall; rsp after 8 STB cycles.
- ERR on beat 2 of 4-beat read → CYC drops next cycle; rsp_err=1, rsp_beats=2; rbuf[2] unchanged.
- Address wrap: WB_ADDR_WIDTH=8, adr=0xFC, len=1 → ADR 0xFC then 0x00.
- Reset mid-burst and, with WB_BURST_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, a slave that never ACKs:
  - reset: CYC=0 the next cycle and no rsp_valid;
  - timeout: rsp_err=1, rsp_beats=0 after 8 cycles.
